wb_rr_arbiter: RTL
==================

// Module: wb_rr_arbiter
// PURPOSE
//  Two-master round-robin Wishbone (pipelined) arbiter sharing one slave bus.
//  - Typical masters: CPU data port and a debug/DMA master; slave side feeds the peripheral decode (LED register at 0x8000_0000, etc.).
//  - Ownership is held for a whole CYC; the non-owner is stalled, never dropped.
// PARAMETERS
//  AW        32   address width
//  DW        32   data width (SEL width = DW/8)
//  TO_CYCLES 255  watchdog limit in cycles, used only with WB_ARB_TIMEOUT_EN; must be >= 1
// PORTS
//  i_clk                          in   1     system clock
//  i_reset_n                      in   1     asynchronous active-low reset
//  i_mN_wb_cyc/stb/we (N=0,1)     in   1     master N bus cycle / strobe / write
//  i_mN_wb_addr                   in   AW    master N address
//  i_mN_wb_data                   in   DW    master N write data
//  i_mN_wb_sel                    in   DW/8  master N byte lanes
//  o_mN_wb_ack/err                out  1     routed from slave to owner only
//  o_mN_wb_stall                  out  1     slave stall if owner, else 1
//  o_mN_wb_data                   out  DW    slave read data (broadcast)
//  o_s_wb_cyc/stb/we              out  1     owner's signals, gated by grant
//  o_s_wb_addr/data/sel           out  AW/DW/DW/8  owner's bus, muxed
//  i_s_wb_ack/err/stall           in   1     slave responses
//  i_s_wb_data                    in   DW    slave read data
// BEHAVIOUR
//  - FSM states IDLE, OWN0, OWN1; state and last-served bit are registers.
//  - Reset values: state=IDLE, last=1 (m0 wins the first tie).
//    All o_s_wb_* = 0. o_mN_wb_ack/err = 0. o_mN_wb_stall = 1.
//  - IDLE: requests are sampled.
//    - Only mN has cyc: go to OWNn.
//    - Both have cyc: grant ~last.
//    - Neither: stay in IDLE.
//    Grant is registered, so the slave sees cyc/stb 1 cycle after the master asserts cyc. No transfer is issued in IDLE.
//  - OWNn:
//    - o_s_wb_* = mN inputs. o_mN_stall = i_s_wb_stall. o_mN_ack/err = slave values.
//    - Other master: stall=1, ack=0, err=0.
//    - If i_mN_wb_cyc=0: go to IDLE and set last=n. The slave cyc drops in that same cycle (combinational gate).
//  - No fairness preemption: an owner may hold the bus indefinitely.
//  - Handover: IDLE is entered for 1 cycle between owners, so back-to-back cycles from different masters are separated by a 1-cycle bubble.
//  - Simultaneous release by the owner and a new request from the other master: IDLE, then the other master is granted.
//  - Pending ack bookkeeping: a 2-bit outstanding counter per grant.
//    - +1 on stb&!stall, -1 on ack|err; both in the same cycle leaves it unchanged.
//    - The owner dropping cyc with the counter >0 is a master protocol violation. The arbiter still releases; late acks are discarded and never routed to the other master.
//    - The counter clears on release.
//  - Asynchronous reset mid-cycle: outputs return to reset values immediately; any in-flight transfer is abandoned.
// CONFIGURATION
//  - WB_ARB_TIMEOUT_EN defined:
//    - An 8..16-bit watchdog counts cycles while outstanding>0 with no ack/err.
//    - At TO_CYCLES it pulses o_mN_wb_err=1 to the owner for 1 cycle, forces o_s_wb_cyc=0 for that cycle, clears outstanding and returns to IDLE (last=n).
//    - The counter resets to 0 on every ack/err and on every grant change.
//  - Undefined: no counter is built; a hung slave hangs the owner forever. Err is only the slave's err.
// STRUCTURE
//  - Shared package header wb_pkg.vh: state encodings (ARB_IDLE=2'd0, ARB_OWN0=2'd1, ARB_OWN1=2'd2), default AW/DW, the LED slave base address.
//  - One sub-module, wb_arb_watchdog: counter plus terminal pulse, instantiated only under WB_ARB_TIMEOUT_EN.
//  - Muxing and gating stay in the top module.
// TESTING
//  - Reset held low: o_s_wb_cyc=0, o_m0/m1_wb_stall=1, acks=0.
//    Release reset, assert m0 cyc/stb/we, addr 0x8000_0000, data 0x2A.
//    -> slave sees the write 1 cycle later; 0-wait slave ack -> o_m0_wb_ack=1, o_m1_wb_ack=0.
//  - m0 and m1 assert cyc in the same cycle after reset.
//    -> m0 granted. m0 drops cyc -> 1 IDLE cycle, then m1 granted.
//    Both request again -> m0 granted (alternation).
//  - m1 owns the bus, slave stall=1 for 3 cycles.
//    -> o_m1_wb_stall tracks it; o_m0_wb_stall=1 throughout.
//    Read returns 0x3F on i_s_wb_data, seen on o_m1_wb_data with o_m1_wb_ack=1.
//  - Pipelined burst: m0 issues 2 stb back-to-back with no stall.
//    -> outstanding reaches 2, then returns to 0 after 2 acks. m0 holds cyc until then; m1 stays stalled.
//  - i_reset_n pulsed low mid-transfer while m1 owns the bus.
//    -> o_s_wb_cyc falls asynchronously; after release the FSM is in IDLE and the first tie goes to m0.
//  - With WB_ARB_TIMEOUT_EN, TO_CYCLES=8: the slave never acks.
//    -> o_m0_wb_err=1 exactly 8 cycles after the accepted stb, o_s_wb_cyc=0, FSM in IDLE.
//    Without the macro, the same stimulus leaves m0 waiting indefinitely with err=0.

Source files
------------

// File: rtl/wb_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter_pkg
// Shared definitions for the two-master Wishbone round-robin arbiter:
//   - arb_state_t : arbiter FSM encoding (IDLE / OWN0 / OWN1)
//   - WB_DEF_AW / WB_DEF_DW : default address / data widths
//   - WB_LED_BASE : base address of the LED register slave
//   - wd_width()  : watchdog counter width for a given cycle limit
// ---------------------------------------------------------------------------
package wb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  localparam int          WB_DEF_AW   = 32;
  localparam int          WB_DEF_DW   = 32;
  localparam logic [31:0] WB_LED_BASE = 32'h8000_0000;

  // Watchdog counter is 8 bits for limits up to 255, otherwise 16 bits.
  function automatic int wd_width(input int limit);
    return (limit < 256) ? 8 : 16;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// ---------------------------------------------------------------------------
// wb_arb_watchdog
// Counts cycles during which the current owner has transfers outstanding
// and the slave gives no response; pulses o_fire for one cycle when the
// count reaches TO_CYCLES. Only instantiated with WB_ARB_TIMEOUT_EN.
// Ports:
//   i_clk      system clock
//   i_reset_n  asynchronous active-low reset
//   i_clr      clear: slave ack/err seen, or no active owner cycle
//   i_active   owner has at least one outstanding transfer
//   o_fire     one-cycle timeout pulse
// ---------------------------------------------------------------------------
module wb_arb_watchdog
  import wb_rr_arbiter_pkg::*;
#(
  parameter int TO_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_active,
  output logic o_fire
);

  localparam int            CW    = wd_width(TO_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TO_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // cnt_q counts waiting cycles already elapsed, so the pulse lands
  // TO_CYCLES cycles after the stb that was accepted.
  assign o_fire = i_active & ~i_clr & (cnt_q == LIMIT);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else if (i_clr || o_fire) begin
      cnt_q <= '0;
    end else if (i_active) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Two-master round-robin arbiter for pipelined Wishbone sharing one slave.
// Ownership is held for a whole CYC; the non-owner is stalled, never dropped.
// A one-cycle IDLE bubble separates consecutive owners.
// Optional feature macro: WB_ARB_TIMEOUT_EN (response watchdog, TO_CYCLES).
// Ports:
//   i_clk, i_reset_n                    clock, async active-low reset
//   i_mN_wb_cyc/stb/we/addr/data/sel    master N request (N = 0, 1)
//   o_mN_wb_ack/err/stall/data          master N response
//   o_s_wb_cyc/stb/we/addr/data/sel     slave request (owner, gated)
//   i_s_wb_ack/err/stall/data           slave response
// ---------------------------------------------------------------------------
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int AW        = WB_DEF_AW,
  parameter int DW        = WB_DEF_DW,
  parameter int TO_CYCLES = 255
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_m0_wb_cyc,
  input  logic          i_m0_wb_stb,
  input  logic          i_m0_wb_we,
  input  logic [AW-1:0] i_m0_wb_addr,
  input  logic [DW-1:0] i_m0_wb_data,
  input  logic [DW/8-1:0] i_m0_wb_sel,
  output logic          o_m0_wb_ack,
  output logic          o_m0_wb_err,
  output logic          o_m0_wb_stall,
  output logic [DW-1:0] o_m0_wb_data,
  input  logic          i_m1_wb_cyc,
  input  logic          i_m1_wb_stb,
  input  logic          i_m1_wb_we,
  input  logic [AW-1:0] i_m1_wb_addr,
  input  logic [DW-1:0] i_m1_wb_data,
  input  logic [DW/8-1:0] i_m1_wb_sel,
  output logic          o_m1_wb_ack,
  output logic          o_m1_wb_err,
  output logic          o_m1_wb_stall,
  output logic [DW-1:0] o_m1_wb_data,
  output logic          o_s_wb_cyc,
  output logic          o_s_wb_stb,
  output logic          o_s_wb_we,
  output logic [AW-1:0] o_s_wb_addr,
  output logic [DW-1:0] o_s_wb_data,
  output logic [DW/8-1:0] o_s_wb_sel,
  input  logic          i_s_wb_ack,
  input  logic          i_s_wb_err,
  input  logic          i_s_wb_stall,
  input  logic [DW-1:0] i_s_wb_data
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;     // 1: m1 served last, so m0 wins a tie
  logic [1:0] outst_q, outst_d;   // outstanding transfers of current owner
  logic       own0, own1, owner_cyc, issued, resp, wd_fire;

  assign own0      = (state_q == ARB_OWN0);
  assign own1      = (state_q == ARB_OWN1);
  assign owner_cyc = own0 ? i_m0_wb_cyc : (own1 ? i_m1_wb_cyc : 1'b0);
  assign resp      = (own0 | own1) & (i_s_wb_ack | i_s_wb_err);
  assign issued    = o_s_wb_stb & ~i_s_wb_stall;

  assign o_m0_wb_data = i_s_wb_data;
  assign o_m1_wb_data = i_s_wb_data;

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .TO_CYCLES (TO_CYCLES)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (~owner_cyc | resp),
    .i_active  (outst_q != 2'd0),
    .o_fire    (wd_fire)
  );
`else
  logic unused_to_cfg;
  assign unused_to_cfg = (TO_CYCLES > 0);
  assign wd_fire       = 1'b0;
`endif

  // Next state, last-served bit and outstanding count
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    outst_d = outst_q;
    case (state_q)
      ARB_IDLE: begin
        outst_d = '0;
        if (i_m0_wb_cyc && i_m1_wb_cyc) state_d = last_q ? ARB_OWN0 : ARB_OWN1;
        else if (i_m0_wb_cyc)           state_d = ARB_OWN0;
        else if (i_m1_wb_cyc)           state_d = ARB_OWN1;
      end
      ARB_OWN0, ARB_OWN1: begin
        if (!owner_cyc || wd_fire) begin
          // Release: any late acks land in IDLE and are discarded.
          state_d = ARB_IDLE;
          last_d  = own1;
          outst_d = '0;
        end else begin
          outst_d = outst_q + {1'b0, issued} - {1'b0, resp};
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Slave-side mux and master-side response routing
  always_comb begin
    o_s_wb_cyc    = 1'b0;
    o_s_wb_stb    = 1'b0;
    o_s_wb_we     = 1'b0;
    o_s_wb_addr   = '0;
    o_s_wb_data   = '0;
    o_s_wb_sel    = '0;
    o_m0_wb_ack   = 1'b0;
    o_m0_wb_err   = 1'b0;
    o_m0_wb_stall = 1'b1;
    o_m1_wb_ack   = 1'b0;
    o_m1_wb_err   = 1'b0;
    o_m1_wb_stall = 1'b1;
    if (own0) begin
      o_s_wb_cyc    = i_m0_wb_cyc & ~wd_fire;
      o_s_wb_stb    = i_m0_wb_cyc & i_m0_wb_stb & ~wd_fire;
      o_s_wb_we     = i_m0_wb_we;
      o_s_wb_addr   = i_m0_wb_addr;
      o_s_wb_data   = i_m0_wb_data;
      o_s_wb_sel    = i_m0_wb_sel;
      o_m0_wb_ack   = i_s_wb_ack;
      o_m0_wb_err   = i_s_wb_err | wd_fire;
      o_m0_wb_stall = i_s_wb_stall | wd_fire;
    end else if (own1) begin
      o_s_wb_cyc    = i_m1_wb_cyc & ~wd_fire;
      o_s_wb_stb    = i_m1_wb_cyc & i_m1_wb_stb & ~wd_fire;
      o_s_wb_we     = i_m1_wb_we;
      o_s_wb_addr   = i_m1_wb_addr;
      o_s_wb_data   = i_m1_wb_data;
      o_s_wb_sel    = i_m1_wb_sel;
      o_m1_wb_ack   = i_s_wb_ack;
      o_m1_wb_err   = i_s_wb_err | wd_fire;
      o_m1_wb_stall = i_s_wb_stall | wd_fire;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      outst_q <= outst_d;
    end
  end

endmodule
